// File: rtl/brisc_pkg.sv
// Shared types and constants for the brisc pipeline writeback path.
// Opcodes follow the RV32 major-opcode encoding.
package brisc_pkg;

  localparam int XLEN        = 32;
  localparam int REG_BITS    = 5;
  localparam int OPCODE_BITS = 7;

  localparam logic [OPCODE_BITS-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_BITS-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_BITS-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_BITS-1:0] OP_IMM    = 7'b0010011;

  typedef struct packed {
    logic [OPCODE_BITS-1:0] opcode;
    logic [REG_BITS-1:0]    rd;
    logic [XLEN-1:0]        alu_result;
    logic [XLEN-1:0]        load_data;
    logic                   xcpt;
    logic [XLEN-1:0]        pc;
  } wb_entry_t;

  typedef enum logic [0:0] {
    RUN       = 1'b0,
    XCPT_HOLD = 1'b1
  } wb_state_e;

  // Stores and branches never produce a register result; x0 is hardwired to zero.
  function automatic logic writes_rf(input logic [OPCODE_BITS-1:0] opcode,
                                     input logic [REG_BITS-1:0]    rd);
    return (rd != {REG_BITS{1'b0}}) && (opcode != OP_STORE) && (opcode != OP_BRANCH);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Completion buffer between memory and writeback stages.
// Power-of-two depth, so pointers wrap by natural overflow.
module wb_fifo import brisc_pkg::*; #(
  parameter int  DEPTH = 2,
  parameter type T     = wb_entry_t
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  T                       din,
  output T                       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T                mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic            do_push;
  logic            do_pop;

  assign full    = (count_r == CW'(DEPTH));
  assign empty   = (count_r == {CW{1'b0}});
  assign count   = count_r;
  assign head    = mem_r[rd_ptr_r];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Payload storage needs no reset: reads are qualified by empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_r[wr_ptr_r] <= din;
  end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: buffers completed instructions, retires them in order to the
// register file, traps the first exception and counts retired instructions.
module writeback_stage import brisc_pkg::*; #(
  parameter int DEPTH    = 2,
  parameter int CNT_BITS = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   stall_wb,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [OPCODE_BITS-1:0] mem_opcode,
  input  logic [REG_BITS-1:0]    mem_rd,
  input  logic [XLEN-1:0]        mem_alu_result,
  input  logic [XLEN-1:0]        mem_load_data,
  input  logic                   mem_xcpt,
  input  logic [XLEN-1:0]        mem_pc,
  output logic                   rf_enable,
  output logic [REG_BITS-1:0]    rd_wb_out,
  output logic [XLEN-1:0]        data_wb_out,
  output logic [OPCODE_BITS-1:0] opcode_wb_out,
  output logic                   xcpt_out,
  output logic [XLEN-1:0]        xcpt_pc_out,
  output logic [CNT_BITS-1:0]    retired_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  wb_entry_t      in_entry;
  wb_entry_t      head;
  logic           full;
  logic           empty;
  logic [CW-1:0]  count;
  logic           accept;
  logic           commit;
  logic [CW-1:0]  count_next;
  wb_state_e      state_r;
  wb_state_e      next_state;
  logic           ready_r;
  logic [XLEN-1:0]     xcpt_pc_r;
  logic [CNT_BITS-1:0] retired_r;

  assign in_entry = '{opcode: mem_opcode, rd: mem_rd, alu_result: mem_alu_result,
                      load_data: mem_load_data, xcpt: mem_xcpt, pc: mem_pc};

  assign accept = mem_valid && ready_r && !full && !flush;
  assign commit = !empty && !stall_wb && (state_r == RUN) && !flush;

  wb_fifo #(.DEPTH(DEPTH), .T(wb_entry_t)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .pop   (commit),
    .flush (flush),
    .din   (in_entry),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Next state and next occupancy; flush overrides everything.
  always_comb begin
    next_state = state_r;
    count_next = count;
    case (state_r)
      RUN:       if (commit && head.xcpt) next_state = XCPT_HOLD; else next_state = RUN;
      XCPT_HOLD: next_state = XCPT_HOLD;
      default:   next_state = RUN;
    endcase
    case ({accept, commit})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
    if (flush) begin
      next_state = RUN;
      count_next = {CW{1'b0}};
    end else begin
      next_state = next_state;
    end
  end

  // Head outputs; an empty buffer drives zeros so the regfile port idles cleanly.
  always_comb begin
    rf_enable     = 1'b0;
    xcpt_out      = 1'b0;
    rd_wb_out     = {REG_BITS{1'b0}};
    data_wb_out   = {XLEN{1'b0}};
    opcode_wb_out = {OPCODE_BITS{1'b0}};
    if (!empty) begin
      rd_wb_out     = head.rd;
      opcode_wb_out = head.opcode;
      data_wb_out   = (head.opcode == OP_LOAD) ? head.load_data : head.alu_result;
      rf_enable     = commit && !head.xcpt && writes_rf(head.opcode, head.rd);
      xcpt_out      = commit && head.xcpt;
    end else begin
      rf_enable = 1'b0;
    end
  end

  // State, ready, exception PC and retirement counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= RUN;
      ready_r   <= 1'b1;
      xcpt_pc_r <= {XLEN{1'b0}};
      retired_r <= {CNT_BITS{1'b0}};
    end else begin
      state_r <= next_state;
      ready_r <= (count_next < CW'(DEPTH)) && (next_state == RUN);
      if (flush) begin
        xcpt_pc_r <= {XLEN{1'b0}};
      end else if (commit && head.xcpt) begin
        xcpt_pc_r <= head.pc;
      end else begin
        xcpt_pc_r <= xcpt_pc_r;
      end
      if (commit && !head.xcpt) retired_r <= retired_r + CNT_BITS'(1);
    end
  end

  assign mem_ready     = ready_r;
  assign xcpt_pc_out   = xcpt_pc_r;
  assign retired_count = retired_r;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage, plus a CNT_BITS=4 instance
// sharing the same stimulus to exercise counter wrap.
module tb_writeback_stage;
  import brisc_pkg::*;

  logic clk = 1'b0;
  logic reset, flush, stall_wb, mem_valid, mem_xcpt;
  logic [OPCODE_BITS-1:0] mem_opcode;
  logic [REG_BITS-1:0]    mem_rd;
  logic [XLEN-1:0]        mem_alu_result, mem_load_data, mem_pc;

  logic                   mem_ready, rf_enable, xcpt_out;
  logic [REG_BITS-1:0]    rd_wb_out;
  logic [XLEN-1:0]        data_wb_out, xcpt_pc_out;
  logic [OPCODE_BITS-1:0] opcode_wb_out;
  logic [31:0]            retired_count;

  logic                   s_ready, s_rf, s_xcpt;
  logic [REG_BITS-1:0]    s_rd;
  logic [XLEN-1:0]        s_data, s_xpc;
  logic [OPCODE_BITS-1:0] s_op;
  logic [3:0]             s_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  writeback_stage #(.DEPTH(2), .CNT_BITS(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .stall_wb(stall_wb), .mem_valid(mem_valid),
    .mem_ready(mem_ready), .mem_opcode(mem_opcode), .mem_rd(mem_rd),
    .mem_alu_result(mem_alu_result), .mem_load_data(mem_load_data), .mem_xcpt(mem_xcpt),
    .mem_pc(mem_pc), .rf_enable(rf_enable), .rd_wb_out(rd_wb_out), .data_wb_out(data_wb_out),
    .opcode_wb_out(opcode_wb_out), .xcpt_out(xcpt_out), .xcpt_pc_out(xcpt_pc_out),
    .retired_count(retired_count)
  );

  writeback_stage #(.DEPTH(2), .CNT_BITS(4)) dut4 (
    .clk(clk), .reset(reset), .flush(flush), .stall_wb(stall_wb), .mem_valid(mem_valid),
    .mem_ready(s_ready), .mem_opcode(mem_opcode), .mem_rd(mem_rd),
    .mem_alu_result(mem_alu_result), .mem_load_data(mem_load_data), .mem_xcpt(mem_xcpt),
    .mem_pc(mem_pc), .rf_enable(s_rf), .rd_wb_out(s_rd), .data_wb_out(s_data),
    .opcode_wb_out(s_op), .xcpt_out(s_xcpt), .xcpt_pc_out(s_xpc),
    .retired_count(s_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic send(input logic [OPCODE_BITS-1:0] op, input logic [REG_BITS-1:0] rd,
                      input logic [XLEN-1:0] alu, input logic [XLEN-1:0] ld,
                      input logic x, input logic [XLEN-1:0] pc);
    mem_valid      = 1'b1;
    mem_opcode     = op;
    mem_rd         = rd;
    mem_alu_result = alu;
    mem_load_data  = ld;
    mem_xcpt       = x;
    mem_pc         = pc;
  endtask

  task automatic idle();
    mem_valid = 1'b0;
    mem_xcpt  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; stall_wb = 1'b0;
    mem_valid = 1'b0; mem_xcpt = 1'b0; mem_opcode = '0; mem_rd = '0;
    mem_alu_result = '0; mem_load_data = '0; mem_pc = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    mid();
    check("rst_ready", mem_ready, 1);
    check("rst_rf", rf_enable, 0);
    check("rst_count", retired_count, 0);
    check("rst_xpc", xcpt_pc_out, 0);
    check("rst_rd", rd_wb_out, 0);

    // 1: ADDI x5 latency one cycle
    next_cycle(); send(OP_IMM, 5'd5, 32'h2A, 32'h0, 1'b0, 32'h10);
    mid(); check("t1_rf_accept_cycle", rf_enable, 0);
    next_cycle(); idle();
    mid();
    check("t1_rf", rf_enable, 1);
    check("t1_rd", rd_wb_out, 5);
    check("t1_data", data_wb_out, 32'h2A);
    check("t1_op", opcode_wb_out, OP_IMM);
    next_cycle(); mid();
    check("t1_count", retired_count, 1);
    check("t1_rf_idle", rf_enable, 0);

    // 2: load data select, x0 and store suppress write but still count
    next_cycle(); send(OP_LOAD, 5'd7, 32'h100, 32'hDEAD, 1'b0, 32'h14);
    next_cycle(); idle();
    mid();
    check("t2_load_rf", rf_enable, 1);
    check("t2_load_rd", rd_wb_out, 7);
    check("t2_load_data", data_wb_out, 32'hDEAD);
    next_cycle(); send(OP_IMM, 5'd0, 32'h5, 32'h0, 1'b0, 32'h18);
    next_cycle(); idle();
    mid(); check("t2_x0_rf", rf_enable, 0);
    next_cycle(); send(OP_STORE, 5'd4, 32'h200, 32'h0, 1'b0, 32'h1C);
    next_cycle(); idle();
    mid(); check("t2_store_rf", rf_enable, 0);
    next_cycle(); mid();
    check("t2_count", retired_count, 4);

    // 3: stall with three back-to-back valids
    next_cycle(); stall_wb = 1'b1; send(OP_IMM, 5'd1, 32'h11, 32'h0, 1'b0, 32'h20);
    mid(); check("t3_ready_a", mem_ready, 1);
    next_cycle(); send(OP_IMM, 5'd2, 32'h22, 32'h0, 1'b0, 32'h24);
    mid();
    check("t3_ready_b", mem_ready, 1);
    check("t3_stall_rf", rf_enable, 0);
    check("t3_stall_hold_rd", rd_wb_out, 1);
    next_cycle(); send(OP_IMM, 5'd3, 32'h33, 32'h0, 1'b0, 32'h28);
    mid(); check("t3_ready_full", mem_ready, 0);
    next_cycle(); idle(); stall_wb = 1'b0;
    mid();
    check("t3_w1_rf", rf_enable, 1);
    check("t3_w1_rd", rd_wb_out, 1);
    check("t3_w1_data", data_wb_out, 32'h11);
    next_cycle(); mid();
    check("t3_w2_rf", rf_enable, 1);
    check("t3_w2_rd", rd_wb_out, 2);
    check("t3_w2_data", data_wb_out, 32'h22);
    check("t3_ready_again", mem_ready, 1);
    next_cycle(); mid();
    check("t3_dropped_rf", rf_enable, 0);
    check("t3_count", retired_count, 6);

    // 4: exception then ADDI x3, then flush
    next_cycle(); send(OP_IMM, 5'd9, 32'h99, 32'h0, 1'b1, 32'h80);
    next_cycle(); send(OP_IMM, 5'd3, 32'h33, 32'h0, 1'b0, 32'h84);
    mid();
    check("t4_xcpt_pulse", xcpt_out, 1);
    check("t4_xcpt_rf", rf_enable, 0);
    next_cycle(); idle();
    mid();
    check("t4_xcpt_low", xcpt_out, 0);
    check("t4_xpc", xcpt_pc_out, 32'h80);
    check("t4_hold_rf", rf_enable, 0);
    check("t4_hold_ready", mem_ready, 0);
    check("t4_count", retired_count, 6);
    next_cycle(); mid();
    check("t4_hold_rf2", rf_enable, 0);
    next_cycle(); flush = 1'b1;
    mid(); check("t4_flush_rf", rf_enable, 0);
    next_cycle(); flush = 1'b0;
    mid();
    check("t4_flush_ready", mem_ready, 1);
    check("t4_flush_xpc", xcpt_pc_out, 0);
    check("t4_flush_rf_empty", rf_enable, 0);
    check("t4_count_after", retired_count, 6);

    // 5: async reset while full and committing
    next_cycle(); stall_wb = 1'b1; send(OP_IMM, 5'd4, 32'h44, 32'h0, 1'b0, 32'h90);
    next_cycle(); send(OP_IMM, 5'd6, 32'h66, 32'h0, 1'b0, 32'h94);
    next_cycle(); idle(); stall_wb = 1'b0;
    mid();
    check("t5_pre_rf", rf_enable, 1);
    check("t5_pre_rd", rd_wb_out, 4);
    #2 reset = 1'b1;
    #1;
    check("t5_rst_rf", rf_enable, 0);
    check("t5_rst_count", retired_count, 0);
    check("t5_rst_rd", rd_wb_out, 0);
    check("t5_rst_ready", mem_ready, 1);
    next_cycle(); reset = 1'b0;
    mid();
    check("t5_post_rf", rf_enable, 0);
    check("t5_post_count4", s_count, 0);

    // 6: counter wrap on the CNT_BITS=4 instance
    for (int i = 0; i < 15; i++) begin
      next_cycle(); send(OP_IMM, 5'd8, 32'(i), 32'h0, 1'b0, 32'h100);
    end
    next_cycle(); idle();
    next_cycle(); mid();
    check("t6_count4_15", s_count, 4'hF);
    check("t6_count32_15", retired_count, 15);
    next_cycle(); send(OP_IMM, 5'd8, 32'h1, 32'h0, 1'b0, 32'h104);
    next_cycle(); send(OP_IMM, 5'd8, 32'h2, 32'h0, 1'b0, 32'h108);
    next_cycle(); idle();
    next_cycle(); mid();
    check("t6_count4_wrap", s_count, 4'h1);
    check("t6_count32_17", retired_count, 17);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
